// File: rtl/ay_audio_pkg.sv
// Shared constants and the mixer-to-PCM conversion for the AY audio output path.
package ay_audio_pkg;

  localparam int I2S_WORD_BITS   = 16;
  localparam int I2S_FRAME_SLOTS = 32;
  localparam int AY_MIX_BITS     = 11;
  localparam int SLOT_W          = $clog2(I2S_FRAME_SLOTS);

  typedef logic signed [I2S_WORD_BITS-1:0] pcm16_t;

  // Midscale subtract is an MSB flip; the shift by 5 fills the 16-bit word exactly.
  function automatic pcm16_t to_pcm16(input logic [AY_MIX_BITS-1:0] mix);
    return pcm16_t'({~mix[AY_MIX_BITS-1], mix[AY_MIX_BITS-2:0], 5'b00000});
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: BCLK toggles every BCLK_DIV CLK cycles, rising first after reset.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET_L,
  output logic bclk,
  output logic fall_stb
);

  localparam logic [7:0] DIV_TC = 8'(BCLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       div_tc;

  assign div_tc = (div_cnt == DIV_TC);

  // High for the one CLK cycle whose closing edge drives BCLK low, so downstream
  // registers enabled by it change on exactly the same edge as BCLK.
  assign fall_stb = div_tc & bclk;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      div_cnt <= 8'd0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= div_tc ? 8'd0 : div_cnt + 8'd1;
      if (div_tc)
        bclk <= ~bclk;
    end
  end

endmodule

// File: rtl/ay_i2s_tx.sv
// Stereo Philips I2S transmitter for the TurboSound mixer outputs (16-bit words, 32 slots/frame).
module ay_i2s_tx
  import ay_audio_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_L,
  input  logic [AY_MIX_BITS-1:0] AUDIO_L,
  input  logic [AY_MIX_BITS-1:0] AUDIO_R,
  input  logic                   MUTE,
  output logic                   I2S_BCLK,
  output logic                   I2S_LRCK,
  output logic                   I2S_DATA,
  output logic                   SAMPLE_TAKEN
);

  logic              bclk;
  logic              fall_stb;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_nxt;
  logic [3:0]        bit_idx;
  logic              data_nxt;
  pcm16_t            hold_l;
  pcm16_t            hold_r;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .CLK      (CLK),
    .RESET_L  (RESET_L),
    .bclk     (bclk),
    .fall_stb (fall_stb)
  );

  assign I2S_BCLK = bclk;
  assign slot_nxt = slot_cnt + SLOT_W'(1);

  // One-bit delay: slots 1..16 carry left bits 15..0, slots 17..31 and the next
  // slot 0 carry right bits 15..0. Bit index is (16 - slot) mod 16 either way,
  // and the left word is selected exactly when the current slot is 0..15.
  assign bit_idx = 4'd0 - slot_nxt[3:0];

  always_comb begin
    data_nxt = 1'b0;
    if (!slot_cnt[SLOT_W-1])
      data_nxt = hold_l[bit_idx];
    else
      data_nxt = hold_r[bit_idx];
  end

  // Stage boundary: everything below updates on the edge that drives BCLK low.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      slot_cnt     <= SLOT_W'(I2S_FRAME_SLOTS - 1);
      hold_l       <= '0;
      hold_r       <= '0;
      I2S_LRCK     <= 1'b0;
      I2S_DATA     <= 1'b0;
      SAMPLE_TAKEN <= 1'b0;
    end else begin
      SAMPLE_TAKEN <= 1'b0;
      if (fall_stb) begin
        slot_cnt <= slot_nxt;
        I2S_LRCK <= slot_nxt[SLOT_W-1];
        I2S_DATA <= data_nxt;
        // Slot 0 still shifts out the old right LSB, captured before this load.
        if (slot_nxt == '0) begin
          hold_l       <= MUTE ? '0 : to_pcm16(AUDIO_L);
          hold_r       <= MUTE ? '0 : to_pcm16(AUDIO_R);
          SAMPLE_TAKEN <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ay_i2s_tx.sv
// Bench for ay_i2s_tx: I2S receiver + scoreboard on two instances (BCLK_DIV 4 and 2).
module tb_ay_i2s_tx;

  logic        CLK = 1'b0;
  logic        RESET_L = 1'b1;
  logic [10:0] AUDIO_L = 11'h400;
  logic [10:0] AUDIO_R = 11'h400;
  logic        MUTE = 1'b0;

  logic bclk_a, lrck_a, data_a, st_a;
  logic bclk_b, lrck_b, data_b, st_b;

  ay_i2s_tx #(.BCLK_DIV(4)) dut_a (
    .CLK(CLK), .RESET_L(RESET_L), .AUDIO_L(AUDIO_L), .AUDIO_R(AUDIO_R), .MUTE(MUTE),
    .I2S_BCLK(bclk_a), .I2S_LRCK(lrck_a), .I2S_DATA(data_a), .SAMPLE_TAKEN(st_a));

  ay_i2s_tx #(.BCLK_DIV(2)) dut_b (
    .CLK(CLK), .RESET_L(RESET_L), .AUDIO_L(AUDIO_L), .AUDIO_R(AUDIO_R), .MUTE(MUTE),
    .I2S_BCLK(bclk_b), .I2S_LRCK(lrck_b), .I2S_DATA(data_b), .SAMPLE_TAKEN(st_b));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion from the arithmetic definition: (mix - midscale) * 32.
  function automatic logic [15:0] ref_pcm(input logic [10:0] a, input logic m);
    int v;
    v = (int'(a) - 1024) * 32;
    return m ? 16'h0000 : 16'(v);
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  logic [10:0] cap_l, cap_r;
  logic        cap_m;
  always @(posedge CLK) begin
    cap_l <= AUDIO_L;
    cap_r <= AUDIO_R;
    cap_m <= MUTE;
  end

  // Receiver / scoreboard state, index 0 = dut_a, 1 = dut_b
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [15:0] sr[2], wl[2], last_l[2], last_r[2];
  logic        p_bclk[2], p_lrck[2], p_data[2], lr_prev[2], have_l[2];
  logic        ob[2], ol[2], od[2], os[2];
  int          last_rise[2], last_st[2], last_lrr[2];
  logic [31:0] sb_e;
  int          dv;

  always @(negedge CLK) begin
    ob[0] = bclk_a; ol[0] = lrck_a; od[0] = data_a; os[0] = st_a;
    ob[1] = bclk_b; ol[1] = lrck_b; od[1] = data_b; os[1] = st_b;
    for (int i = 0; i < 2; i++) begin
      dv = (i == 0) ? 4 : 2;
      if (!RESET_L) begin
        p_bclk[i] = 1'b0; p_lrck[i] = 1'b0; p_data[i] = 1'b0;
        lr_prev[i] = 1'b0; have_l[i] = 1'b0;
        last_rise[i] = -1; last_st[i] = -1; last_lrr[i] = -1;
        if (i == 0) q0.delete(); else q1.delete();
      end else begin
        if (os[i]) begin
          sb_e = {ref_pcm(cap_l, cap_m), ref_pcm(cap_r, cap_m)};
          if (i == 0) q0.push_back(sb_e); else q1.push_back(sb_e);
          if (last_st[i] >= 0) check("st_spacing", cyc - last_st[i], 64 * dv);
          last_st[i] = cyc;
        end
        if ((od[i] !== p_data[i]) || (ol[i] !== p_lrck[i]))
          check("change_on_fall", 32'(p_bclk[i] & ~ob[i]), 1);
        if (ol[i] && !p_lrck[i]) begin
          if (last_lrr[i] >= 0) check("lrck_period", cyc - last_lrr[i], 64 * dv);
          last_lrr[i] = cyc;
        end
        if (ob[i] && !p_bclk[i]) begin
          if (last_rise[i] >= 0) check("bclk_period", cyc - last_rise[i], 2 * dv);
          last_rise[i] = cyc;
          sr[i] = {sr[i][14:0], od[i]};
          if (ol[i] != lr_prev[i]) begin
            if (ol[i]) begin
              wl[i] = sr[i];
              have_l[i] = 1'b1;
            end else if (have_l[i]) begin
              last_l[i] = wl[i];
              last_r[i] = sr[i];
              if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0))
                check("sb_empty", 0, 1);
              else begin
                sb_e = (i == 0) ? q0.pop_front() : q1.pop_front();
                check(i == 0 ? "pair_div4" : "pair_div2", {wl[i], sr[i]}, sb_e);
              end
            end
          end
          lr_prev[i] = ol[i];
        end
        p_bclk[i] = ob[i]; p_lrck[i] = ol[i]; p_data[i] = od[i];
      end
    end
  end

  task automatic wait_st();
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge CLK);
      if (st_a) break;
    end
    if (k == 2000) check("st_timeout", 0, 1);
  endtask

  task automatic wait_falls(input int n);
    int c;
    logic pb;
    c = 0;
    pb = bclk_a;
    for (int k = 0; k < 5000 && c < n; k++) begin
      @(negedge CLK);
      if (pb && !bclk_a) c++;
      pb = bclk_a;
    end
    if (c < n) check("fall_timeout", c, n);
  endtask

  task automatic release_check();
    int n;
    logic pb;
    @(negedge CLK);
    RESET_L = 1'b1;
    pb = bclk_a;
    for (n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (pb && !bclk_a) break;
      pb = bclk_a;
    end
    check("first_fall_delay", n, 8);
    check("first_slot_lrck", lrck_a, 0);
    check("first_slot_data", data_a, 0);
    check("first_slot_taken", st_a, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bclk_a"}, bclk_a, 0);
    check({tag, "_lrck_a"}, lrck_a, 0);
    check({tag, "_data_a"}, data_a, 0);
    check({tag, "_st_a"},   st_a,   0);
    check({tag, "_bclk_b"}, bclk_b, 0);
    check({tag, "_lrck_b"}, lrck_b, 0);
    check({tag, "_data_b"}, data_b, 0);
    check({tag, "_st_b"},   st_b,   0);
  endtask

  typedef struct {
    logic [10:0] l;
    logic [10:0] r;
    logic        m;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{11'h400, 11'h400, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{11'h7FF, 11'h000, 1'b0, 16'h7FE0, 16'h8000};
    tbl[2] = '{11'h000, 11'h7FF, 1'b0, 16'h8000, 16'h7FE0};
    tbl[3] = '{11'h401, 11'h3FF, 1'b0, 16'h0020, 16'hFFE0};
    tbl[4] = '{11'h555, 11'h2AA, 1'b0, 16'h2AA0, 16'hD540};
    tbl[5] = '{11'h7FF, 11'h7FF, 1'b1, 16'h0000, 16'h0000};

    #1 RESET_L = 1'b0;
    repeat (3) @(negedge CLK);
    check_zero("reset");
    release_check();

    // Static vectors: hold inputs for a full frame, then read the decoded pair.
    foreach (tbl[t]) begin
      @(negedge CLK);
      AUDIO_L = tbl[t].l; AUDIO_R = tbl[t].r; MUTE = tbl[t].m;
      wait_st();
      wait_st();
      repeat (10) @(negedge CLK);
      check("vec_left_div4",  last_l[0], tbl[t].el);
      check("vec_right_div4", last_r[0], tbl[t].er);
      check("vec_left_div2",  last_l[1], tbl[t].el);
      check("vec_right_div2", last_r[1], tbl[t].er);
    end
    MUTE = 1'b0;

    // Mute asserted mid-frame only affects the next capture.
    AUDIO_L = 11'h7FF; AUDIO_R = 11'h7FF;
    wait_st();
    wait_st();
    wait_falls(10);
    MUTE = 1'b1;
    wait_st();
    repeat (10) @(negedge CLK);
    check("mute_cur_left",  last_l[0], 16'h7FE0);
    check("mute_cur_right", last_r[0], 16'h7FE0);
    wait_st();
    repeat (10) @(negedge CLK);
    check("mute_next_left",  last_l[0], 16'h0000);
    check("mute_next_right", last_r[0], 16'h0000);
    @(negedge CLK);
    MUTE = 1'b0;
    wait_st();
    wait_st();
    repeat (10) @(negedge CLK);
    check("unmute_left",  last_l[0], 16'h7FE0);
    check("unmute_right", last_r[0], 16'h7FE0);

    // Atomic capture: inputs change every CLK from a counter, then randomly.
    for (int k = 0; k < 800; k++) begin
      @(negedge CLK);
      AUDIO_L = 11'(k);
      AUDIO_R = 11'(k * 3 + 17);
    end
    for (int k = 0; k < 800; k++) begin
      @(negedge CLK);
      AUDIO_L = 11'($urandom);
      AUDIO_R = 11'($urandom);
      MUTE = ($urandom_range(0, 15) == 0);
    end
    @(negedge CLK);
    MUTE = 1'b0;
    wait_st();
    wait_st();

    // Reset mid-frame in slot 20.
    AUDIO_L = 11'h7FF; AUDIO_R = 11'h5A5;
    wait_st();
    wait_falls(20);
    @(posedge CLK);
    #2 RESET_L = 1'b0;
    #1 check_zero("async_reset");
    repeat (2) @(negedge CLK);
    release_check();
    wait_st();
    wait_st();
    repeat (10) @(negedge CLK);
    check("post_reset_left",  last_l[0], 16'h7FE0);
    check("post_reset_right", last_r[0], 16'h34A0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ay_i2s_tx.md
# ay_i2s_tx

Stereo I2S transmitter that sits directly downstream of the TurboSound mixer. It takes the mixer's unsigned 11-bit left/right outputs and converts them to signed 16-bit PCM. It serialises the PCM as standard Philips I2S (32 BCLK per frame, 16 bits per channel, MSB first) for the board's external audio DAC. Both channels are captured atomically once per frame, so a left/right pair always comes from the same CLK cycle.

## Interface

**Parameters**
- BCLK_DIV, default 4: number of CLK cycles per BCLK half-period. Legal range is 2..255.

**Ports**
- CLK, input, 1: system clock. It is the same clock that drives the mixer.
- RESET_L, input, 1: reset. Asynchronous and active-low; deassertion is synchronous to CLK.
- AUDIO_L, input, 11: left mixer output, unsigned, midscale 11'h400.
- AUDIO_R, input, 11: right mixer output, unsigned, midscale 11'h400.
- MUTE, input, 1: when high, zero samples are sent. It is sampled at frame capture.
- I2S_BCLK, output, 1: bit clock, registered.
- I2S_LRCK, output, 1: word select. 0 means left, 1 means right. Registered.
- I2S_DATA, output, 1: serial data, registered. It changes only on BCLK falling edges.
- SAMPLE_TAKEN, output, 1: one-CLK pulse in the cycle the L/R pair is captured.

## Operation

**Reset values**
- All outputs are 0.
- The divider count is 0.
- The slot counter is 31.
- The left/right hold registers are 16'h0000.

**BCLK generation**
- The divider counts 0..BCLK_DIV-1.
- On terminal count it wraps to 0 and toggles BCLK.
- The first toggle after reset is a rising edge.

**Slots**
- A frame is 32 slots, numbered 0..31.
- Each BCLK falling edge advances the slot counter modulo 32 and begins that slot.
- All output changes are registered in the same CLK cycle that drives BCLK low.

**LRCK**
- LRCK = 0 in slots 0–15.
- LRCK = 1 in slots 16–31.

**DATA (one-bit I2S delay)**
- Slot 0 carries bit 0 of the previous frame's right word.
- Slots 1–15 carry left bits 15..1.
- Slot 16 carries left bit 0.
- Slots 17–31 carry right bits 15..1.

**Capture**
- Capture happens on the falling edge that begins slot 0.
- Both AUDIO_L and AUDIO_R are converted and loaded into the hold registers.
- SAMPLE_TAKEN pulses in that cycle.
- I2S_DATA in slot 0 still carries the old right word's bit 0, so the old right LSB is retained.

**Conversion**
- pcm = {~AUDIO[10], AUDIO[9:0], 5'b0000}. This is a midscale subtract followed by a shift left by 5.
- There is no rounding and no saturation; this is exact for the full input range.
- When MUTE=1 at capture, both words are 16'h0000.

**Boundary conditions**
- Input changes between captures are ignored.
- MUTE toggling mid-frame takes effect at the next slot 0 only.
- Reset mid-frame immediately returns all state to the reset values. After release, the first falling edge starts a fresh slot 0, and its slot-0 bit is 0 because the hold registers are cleared.

## Timing

- BCLK period = 2·BCLK_DIV CLK cycles.
- Frame = 64·BCLK_DIV CLK cycles. With the default BCLK_DIV=4 this is 256 CLK.
- The first falling edge occurs 2·BCLK_DIV CLK cycles after the RESET_L release edge. It begins slot 0.
- Capture-to-first-MSB latency is exactly one BCLK period: left bit 15 appears at the start of slot 1.
- Input-to-last-bit latency is 33 BCLK periods: the right LSB is sent in slot 0 of the next frame.
- All outputs come directly from flops, with no combinational path from inputs to outputs.

## Structure

**Package ay_audio_pkg**
- localparam I2S_WORD_BITS = 16.
- localparam I2S_FRAME_SLOTS = 32.
- localparam AY_MIX_BITS = 11.
- Function to_pcm16(mix), which implements the conversion rule.

**Sub-module i2s_bclk_gen**
- Holds the divider and BCLK flop.
- Outputs bclk, plus a one-CLK fall_stb pulse that is coincident with BCLK going low.

**Top level**
- Holds the slot counter, hold registers, output mux and output registers.
- Total RTL is about 150–200 lines.

## Test plan

- **Zero point:** AUDIO_L = AUDIO_R = 11'h400, BCLK_DIV=4 → both decoded words 16'h0000; BCLK period 8 CLK; LRCK period 256 CLK.
- **Full-scale extremes:** AUDIO_L=11'h7FF, AUDIO_R=11'h000 → left word 16'h7FE0 and right word 16'h8000, decoded by a bench I2S receiver with the one-bit delay. Also check the right LSB (0) in the next frame's slot 0.
- **Atomic capture:** change AUDIO_L and AUDIO_R every CLK from a counter → each decoded pair equals the counter value in the SAMPLE_TAKEN cycle; exactly one SAMPLE_TAKEN per 256 CLK.
- **Mute:**
  - Assert MUTE in slot 10 with AUDIO=11'h7FF → the current frame is still sent as 16'h7FE0; the next frame's words are 16'h0000.
  - Deassert MUTE → audio returns at the following capture.
- **Reset mid-frame:** assert RESET_L low in slot 20 →
  - all outputs are 0 asynchronously, within the reset cycle;
  - after release, the first BCLK fall is at +8 CLK;
  - the slot-0 bit is 0 and LRCK is low.
- **Divider corner:** BCLK_DIV=2 → BCLK period 4 CLK, frame 128 CLK, with correct data. Check for no glitches: BCLK and LRCK each change at most once per CLK, and DATA changes only on falling edges.
